// File: rtl/pc_if_stage.sv
// Instruction-fetch stage: a program counter over a 10-bit word-indexed
// instruction memory, plus the IF/ID pipeline register that feeds decode.
// After reset a one-cycle BOOT state lets the memory settle on RESET_PC
// before the first instruction is accepted into IF/ID.
module pc_if_stage #(
    parameter logic [9:0]  RESET_PC = 10'd0,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic        jump,
    input  logic [9:0]  jump_target,
    input  logic [31:0] inst,
    output logic [9:0]  pc,
    output logic [31:0] id_inst,
    output logic [9:0]  id_pc_plus1,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  pc_nxt;
    logic [9:0]  pc_plus1;
    logic        capture;
    logic        squash;

    // 10-bit addition wraps 1023 -> 0 on its own
    assign pc_plus1 = pc + 10'd1;

    // Next-state, next-pc and IF/ID update decisions; BOOT freezes everything
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        squash    = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                state_nxt = RUN;
                // Redirects win over stall; jump wins over branch
                if (jump) begin
                    pc_nxt = jump_target;
                end else if (branch_taken) begin
                    pc_nxt = branch_target;
                end else if (!stall) begin
                    pc_nxt = pc_plus1;
                end
                // Flush squashes regardless of stall; otherwise a free slot captures
                squash  = flush;
                capture = !flush && !stall;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // FSM state and program counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // IF/ID pipeline register: capture, squash to bubble, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst     <= NOP_INST;
            id_pc_plus1 <= 10'd0;
            id_valid    <= 1'b0;
        end else if (squash) begin
            id_inst     <= NOP_INST;
            id_pc_plus1 <= 10'd0;
            id_valid    <= 1'b0;
        end else if (capture) begin
            id_inst     <= inst;
            id_pc_plus1 <= pc_plus1;
            id_valid    <= 1'b1;
        end
    end

    // Count of instructions accepted into IF/ID, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else if (capture) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
